// File: rtl/fp_add_align_stage.sv
// fp_add_align_stage: unpacks a pair of IEEE-754 operands, puts both on the
// larger exponent and shifts the smaller mantissa right one bit per cycle,
// folding every bit that drops off the end into a sticky bit.
module fp_add_align_stage #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_W+MAN_W:0]       a,
  input  logic [EXP_W+MAN_W:0]       b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [EXP_W+1:0]    z_e,
  output logic [MAN_W+3:0]           a_m,
  output logic [MAN_W+3:0]           b_m,
  output logic                       a_s,
  output logic                       b_s,
  output logic                       a_nan,
  output logic                       b_nan,
  output logic                       a_inf,
  output logic                       b_inf
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int MW   = MAN_W + 4;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] EMIN_E = EW'(1 - BIAS);

  typedef enum logic [1:0] {IDLE, UNPACK, ALIGN, DONE} state_t;

  state_t state, state_nxt;

  logic [W-1:0]  a_r, b_r;
  logic [EW-1:0] count;
  logic          sel_b;

  // One alignment step: shift right, the lowest bit keeps the OR of what falls off.
  function automatic logic [MW-1:0] shr_sticky(input logic [MW-1:0] m);
    return {1'b0, m[MW-1:2], m[1] | m[0]};
  endfunction

  // Collapse a mantissa shifted entirely out of range into its sticky bit.
  function automatic logic [MW-1:0] flush_sticky(input logic [MW-1:0] m);
    return {{(MW-1){1'b0}}, |m};
  endfunction

  // Field extraction and exponent comparison on the captured operands
  logic [EXP_W-1:0]       ea, eb;
  logic [MAN_W-1:0]       fa, fb;
  logic                   zero_a, zero_b, emax_a, emax_b;
  logic                   nan_a, nan_b, inf_a, inf_b, special;
  logic signed [EW-1:0]   exp_a_raw, exp_b_raw, exp_a, exp_b, exp_diff;
  logic [EW-1:0]          d_abs;
  logic                   b_smaller, far, no_shift;
  logic [MW-1:0]          man_a, man_b;

  assign ea        = a_r[W-2:MAN_W];
  assign eb        = b_r[W-2:MAN_W];
  assign fa        = a_r[MAN_W-1:0];
  assign fb        = b_r[MAN_W-1:0];
  assign zero_a    = (ea == '0) && (fa == '0);
  assign zero_b    = (eb == '0) && (fb == '0);
  assign emax_a    = &ea;
  assign emax_b    = &eb;
  assign nan_a     = emax_a && (fa != '0);
  assign nan_b     = emax_b && (fb != '0);
  assign inf_a     = emax_a && (fa == '0);
  assign inf_b     = emax_b && (fb == '0);
  assign special   = emax_a | emax_b;
  assign exp_a_raw = (ea == '0) ? EMIN_E : ($signed({2'b00, ea}) - BIAS_E);
  assign exp_b_raw = (eb == '0) ? EMIN_E : ($signed({2'b00, eb}) - BIAS_E);
  // A zero operand borrows the other exponent so it never forces a shift.
  assign exp_a     = (zero_a && !zero_b) ? exp_b_raw : exp_a_raw;
  assign exp_b     = (zero_b && !zero_a) ? exp_a_raw : exp_b_raw;
  assign exp_diff  = exp_a - exp_b;
  assign d_abs     = exp_diff[EW-1] ? $unsigned(-exp_diff) : $unsigned(exp_diff);
  assign b_smaller = !exp_diff[EW-1] && (exp_diff != '0);
  assign far       = d_abs >= EW'(MW);
  assign no_shift  = special || (d_abs == '0) || far;
  assign man_a     = {ea != '0, fa, 3'b000};
  assign man_b     = {eb != '0, fb, 3'b000};

  assign in_ready  = rst_n & (state == IDLE);
  assign out_valid = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nxt = UNPACK;
      UNPACK:  state_nxt = no_shift ? DONE : ALIGN;
      ALIGN:   if (count == EW'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, unpack and iterative alignment datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      count <= '0;
      sel_b <= 1'b0;
      z_e   <= '0;
      a_m   <= '0;
      b_m   <= '0;
      a_s   <= 1'b0;
      b_s   <= 1'b0;
      a_nan <= 1'b0;
      b_nan <= 1'b0;
      a_inf <= 1'b0;
      b_inf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r <= a;
            b_r <= b;
          end
        end
        UNPACK: begin
          z_e   <= b_smaller ? exp_a : exp_b;
          a_m   <= (!special && far && !b_smaller) ? flush_sticky(man_a) : man_a;
          b_m   <= (!special && far &&  b_smaller) ? flush_sticky(man_b) : man_b;
          a_s   <= a_r[W-1];
          b_s   <= b_r[W-1];
          a_nan <= nan_a;
          b_nan <= nan_b;
          a_inf <= inf_a;
          b_inf <= inf_b;
          count <= d_abs;
          sel_b <= b_smaller;
        end
        ALIGN: begin
          if (sel_b) b_m <= shr_sticky(b_m);
          else       a_m <= shr_sticky(a_m);
          count <= count - EW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_align_stage.sv
// Bench for fp_add_align_stage: directed cases plus randomized operand pairs
// against an arithmetic reference model.
module tb_fp_add_align_stage;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        a, b;
  logic               out_valid;
  logic               out_ready;
  logic signed [9:0]  z_e;
  logic [26:0]        a_m, b_m;
  logic               a_s, b_s, a_nan, b_nan, a_inf, b_inf;

  int checks = 0;
  int errors = 0;

  logic [9:0]  e_ze;
  logic [26:0] e_am, e_bm;
  logic        e_as, e_bs, e_anan, e_bnan, e_ainf, e_binf;
  int          e_lat;

  fp_add_align_stage #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .z_e(z_e), .a_m(a_m), .b_m(b_m), .a_s(a_s), .b_s(b_s),
    .a_nan(a_nan), .b_nan(b_nan), .a_inf(a_inf), .b_inf(b_inf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Right shift by d where the result LSB is the OR of every bit at or below
  // position d of the original value (the sticky bit).
  function automatic longint sticky_shift(input longint m, input int d);
    int     k;
    longint lost;
    k    = (d > 40) ? 40 : d;
    lost = m & ((longint'(1) << k) - 1);
    return (m >> k) | ((lost != 0) ? longint'(1) : longint'(0));
  endfunction

  // Reference: unbiased exponents as integers, mantissas as integers scaled by 8.
  function automatic void ref_model(input logic [31:0] x, input logic [31:0] y);
    int     ex, ey, fx, fy, ux, uy, d;
    bit     zx, zy, special;
    longint mx, my;
    ex = int'(x[30:23]);  fx = int'(x[22:0]);
    ey = int'(y[30:23]);  fy = int'(y[22:0]);
    ux = (ex == 0) ? -126 : ex - 127;
    uy = (ey == 0) ? -126 : ey - 127;
    zx = (ex == 0) && (fx == 0);
    zy = (ey == 0) && (fy == 0);
    if (zx && !zy) ux = uy;
    if (zy && !zx) uy = ux;
    mx = (longint'(fx) + ((ex != 0) ? (longint'(1) << 23) : longint'(0))) << 3;
    my = (longint'(fy) + ((ey != 0) ? (longint'(1) << 23) : longint'(0))) << 3;
    e_anan  = (ex == 255) && (fx != 0);
    e_bnan  = (ey == 255) && (fy != 0);
    e_ainf  = (ex == 255) && (fx == 0);
    e_binf  = (ey == 255) && (fy == 0);
    e_as    = x[31];
    e_bs    = y[31];
    special = (ex == 255) || (ey == 255);
    d       = (ux > uy) ? ux - uy : uy - ux;
    e_ze    = 10'((ux > uy) ? ux : uy);
    if (!special) begin
      if (ux < uy)      mx = sticky_shift(mx, d);
      else if (uy < ux) my = sticky_shift(my, d);
    end
    e_am  = mx[26:0];
    e_bm  = my[26:0];
    e_lat = (special || d == 0 || d >= 27) ? 1 : 1 + d;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(1));
    check({tag, ".z_e"},   64'($unsigned(z_e)), 64'(e_ze));
    check({tag, ".a_m"},   64'(a_m),   64'(e_am));
    check({tag, ".b_m"},   64'(b_m),   64'(e_bm));
    check({tag, ".a_s"},   64'(a_s),   64'(e_as));
    check({tag, ".b_s"},   64'(b_s),   64'(e_bs));
    check({tag, ".a_nan"}, 64'(a_nan), 64'(e_anan));
    check({tag, ".b_nan"}, 64'(b_nan), 64'(e_bnan));
    check({tag, ".a_inf"}, 64'(a_inf), 64'(e_ainf));
    check({tag, ".b_inf"}, 64'(b_inf), 64'(e_binf));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".in_ready"},  64'(in_ready),  64'(0));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(0));
    check({tag, ".all"}, 64'({$unsigned(z_e), a_m, b_m, a_s, b_s, a_nan, b_nan, a_inf, b_inf}), 64'(0));
  endtask

  // Issue one operand pair, wait for out_valid, compare against the model,
  // and (if out_ready is high) confirm the return to IDLE.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input string tag);
    int edges;
    ref_model(x, y);
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(in_ready), 64'(1));
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    edges = 0;
    while (edges < 64) begin
      @(posedge clk);
      #1;
      edges++;
      if (out_valid) break;
    end
    check({tag, ".latency"}, 64'(edges), 64'(e_lat));
    check_outputs(tag);
    if (out_ready) begin
      @(posedge clk);
      #1;
      check({tag, ".drop"},  64'(out_valid), 64'(0));
      check({tag, ".ready"}, 64'(in_ready),  64'(1));
    end
  endtask

  initial begin
    logic [31:0] x, y;
    int          ey, mode;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h3F800000, 32'h40000000, "t1");
    run_op(32'h3F800000, 32'h33800000, "t2");
    run_op(32'h3F800000, 32'h00000001, "t3");
    run_op(32'h7FC00000, 32'hFF800000, "t4");

    // Backpressure: result must hold and in_valid pulses must be ignored.
    out_ready = 1'b0;
    run_op(32'h3F800000, 32'h40000000, "t5");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("t5.hold_ready", 64'(in_ready), 64'(0));
      check_outputs("t5.hold");
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t5.release_valid", 64'(out_valid), 64'(0));
    check("t5.release_ready", 64'(in_ready),  64'(1));

    // Reset in the middle of alignment discards the operation.
    @(negedge clk);
    a = 32'h3F800000; b = 32'h33800000; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t6.mid_valid", 64'(out_valid), 64'(0));
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("t6.abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) break;
    end
    check("t6.no_stale", 64'(out_valid), 64'(0));
    run_op(32'h00000000, 32'h3F800000, "t6.after");

    // Randomized pairs across near exponents, zeros/denormals and specials.
    for (int n = 0; n < 60; n++) begin
      x    = $urandom;
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: y = $urandom;
        1: begin
          ey = int'(x[30:23]) + int'($urandom_range(0, 60)) - 30;
          if (ey < 1)   ey = 1;
          if (ey > 254) ey = 254;
          y = {1'($urandom), 8'(ey), 23'($urandom)};
        end
        2: y = ($urandom_range(0, 3) == 0) ? {1'($urandom), 31'h0}
                                           : {1'($urandom), 8'h00, 23'($urandom)};
        default: y = {1'($urandom), 8'hFF, ($urandom_range(0, 1) == 0) ? 23'h0 : 23'($urandom)};
      endcase
      if ($urandom_range(0, 1) == 1) run_op(y, x, "rnd");
      else                           run_op(x, y, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
